rr_arbiter_8: RTL
=================

// Module: rr_arbiter_8
// PURPOSE
//  Round-robin stream arbiter for 8 valid/ready sources; upstream control stage of mux_8.
//  select_o drives the 8:1 data mux select. The mux output plus valid_o/ready_i form one
//  downstream stream. Optional packet locking and burst limit give fair sharing of a single sink.
// PARAMETERS
//  PACKET_MODE  1  1: grant held until the beat with last_i[select_o]; 0: grant released after every beat
//  MAX_BURST    0  max beats per grant (0 = unlimited); forces release even mid-packet
// PORTS
//  clk_i      in   1  clock; all state updates on rising edge
//  rst_n_i    in   1  asynchronous active-low reset
//  valid_i    in   8  per-source beat valid
//  last_i     in   8  per-source last beat of packet; sampled only on a beat
//  ready_o    out  8  per-source ready; only the granted bit can be 1
//  valid_o    out  1  downstream valid, paired with mux_8.data_o
//  ready_i    in   1  downstream ready
//  select_o   out  3  binary index of the granted source; mux_8 select
//  grant_o    out  8  one-hot grant, all-zero when idle
//  busy_o     out  1  1 while a grant is held
// BEHAVIOUR
//  Reset (asynchronous, immediate): state=IDLE, select_o=0, grant_o=0, ptr=0, beat_cnt=0.
//   This forces valid_o=0, ready_o=0 and busy_o=0. Reset mid-packet drops the packet;
//   the source must resend it.
//  Internal ptr[2:0] = highest-priority index. Search order: ptr, ptr+1, ..., ptr+7 (mod 8).
//  FSM:
//   IDLE: if |valid_i: win = first index in search order with valid_i=1.
//     Next edge: select_o<=win, grant_o<=1<<win, beat_cnt<=0, state<=BUSY.
//     Otherwise hold. select_o keeps its last value in IDLE.
//   BUSY: select_o and grant_o are stable and must not change until release.
//     valid_o  = valid_i[select_o]  (combinational)
//     ready_o  = grant_o & {8{ready_i}}  (combinational)
//     beat     = valid_o & ready_i
//     release  = beat & (PACKET_MODE==0 | last_i[select_o]
//                        | (MAX_BURST!=0 & beat_cnt==MAX_BURST-1))
//     On beat without release: beat_cnt++.
//     On release: state<=IDLE, grant_o<=0, ptr<=select_o+1 (7 wraps to 0), beat_cnt<=0.
//  Timing:
//   - Grant latency: 1 cycle from valid_i seen in IDLE to busy_o=1.
//   - One dead cycle (IDLE) between consecutive grants.
//   - Max throughput PACKET_MODE=0: 1 beat per 2 cycles; packet mode: 1 beat per cycle within a grant.
//  Boundary conditions:
//   - Granted source deasserts valid_i mid-packet: grant held, valid_o=0, no timeout.
//   - ready_i=0 indefinitely: grant held, no beat, beat_cnt unchanged.
//   - Released source still valid: rejoins arbitration with lowest priority.
//   - No simultaneous grant+release path: release always passes through IDLE.
//   - last_i and valid_i of non-granted sources are ignored in BUSY.
//   - beat_cnt width = $clog2(MAX_BURST+1), min 1; unused when MAX_BURST=0.
//  valid_o must never depend on ready_i.
// TESTING
//  1. Reset: assert rst_n_i low mid-packet with ready_i=1 -> same-cycle grant_o=0, valid_o=0,
//     ready_o=0; after release, valid_i=8'h01 -> grant_o=8'h01.
//  2. PACKET_MODE=0, valid_i=8'hFF, ready_i=1 -> select_o sequence 0,1,...,7,0 with a
//     new grant every 2 cycles; exactly 1 beat per grant.
//  3. PACKET_MODE=1, src2 and src5 valid, src2 sends 4 beats with last on beat 4, ready_i
//     toggling 1/0 -> select_o=2 for all 4 beats (7 cycles), then select_o=5.
//  4. Wrap: after a grant to src7, valid_i=8'h41 -> src0 granted before src6.
//  5. MAX_BURST=4, src3 sends a 10-beat packet, src1 valid -> grant sequence
//     3 (4 beats), 1, 3 (4 beats), 1, 3 (2 beats).
//  6. Backpressure: ready_i=0 for 20 cycles while busy -> select_o/grant_o stable,
//     ready_o=0, no release; ready_i=1 resumes the same packet.

Source files
------------

// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: handshake bundle between 8 sources, the arbiter and the
// downstream sink.
//   valid_i/last_i : per-source beat valid / last beat of packet
//   ready_o        : per-source ready (only the granted bit can be 1)
//   valid_o/ready_i: downstream stream handshake
//   select_o       : binary index of granted source (mux_8 select)
//   grant_o        : one-hot grant, zero when idle
//   busy_o         : grant currently held
// master = arbiter side, slave = sources/sink side.
interface rr_arbiter_8_if;
  logic [7:0] valid_i;
  logic [7:0] last_i;
  logic [7:0] ready_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] select_o;
  logic [7:0] grant_o;
  logic       busy_o;

  modport master (
    input  valid_i, last_i, ready_i,
    output ready_o, valid_o, select_o, grant_o, busy_o
  );

  modport slave (
    output valid_i, last_i, ready_i,
    input  ready_o, valid_o, select_o, grant_o, busy_o
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin stream arbiter for 8 valid/ready sources, control
// stage in front of mux_8.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : rr_arbiter_8_if.master (per-source valid/last/ready, downstream
//             valid/ready, select, one-hot grant, busy)
// PACKET_MODE=1 holds a grant until the granted source's last beat;
// PACKET_MODE=0 releases after every beat. MAX_BURST>0 caps beats per grant.
// Every release returns to IDLE for one cycle before the next grant.
module rr_arbiter_8 #(
  parameter bit PACKET_MODE = 1'b1,
  parameter int MAX_BURST   = 0
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  rr_arbiter_8_if.master bus
);

  localparam int BW = (MAX_BURST <= 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = (MAX_BURST <= 0) ? '0 : BW'(MAX_BURST - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [2:0]    ptr;       // highest-priority index
  logic [2:0]    sel;
  logic [7:0]    gnt;
  logic [BW-1:0] beat_cnt;
  logic [2:0]    win;
  logic          beat, rel, burst_end;

  // Scan from furthest to nearest offset so the nearest valid source to ptr
  // is the last (winning) assignment.
  always_comb begin
    win = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (bus.valid_i[ptr + 3'(k)]) win = ptr + 3'(k);
    end
  end

  // valid_o is built only from state and source valid, never from ready_i.
  assign bus.valid_o  = (state == BUSY) & bus.valid_i[sel];
  assign bus.ready_o  = gnt & {8{bus.ready_i}};
  assign bus.select_o = sel;
  assign bus.grant_o  = gnt;
  assign bus.busy_o   = (state == BUSY);

  assign beat      = bus.valid_o & bus.ready_i;
  assign burst_end = (MAX_BURST > 0) && (beat_cnt == BURST_LAST);
  assign rel       = beat & (!PACKET_MODE | bus.last_i[sel] | burst_end);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      sel      <= '0;
      gnt      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.valid_i) begin
            sel      <= win;
            gnt      <= 8'b1 << win;
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        default: begin
          if (rel) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= sel + 3'd1;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
      endcase
    end
  end

endmodule
